// File: rtl/riscv_dmem_ctrl_if.sv
// rtl/riscv_dmem_ctrl_if.sv - core request and DRAM port bundle for the data-memory controller
interface riscv_dmem_ctrl_if #(
    parameter int ADDR_W = 64
);
    logic              req_rd;
    logic              req_wr;
    logic [ADDR_W-1:0] req_addr;
    logic [63:0]       req_wdata;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic              stall;
    logic              rsp_valid;
    logic [63:0]       rsp_rdata;
    logic              misaligned;
    logic              bus_err;
    logic              mem_rden;
    logic              mem_wren;
    logic [ADDR_W-1:0] mem_addr;
    logic [63:0]       mem_wdata;
    logic [7:0]        mem_byteen;
    logic [63:0]       mem_rdata;
    logic              mem_ready;

    // controller side
    modport slave (
        input  req_rd, req_wr, req_addr, req_wdata, req_size, req_unsigned,
        input  mem_rdata, mem_ready,
        output stall, rsp_valid, rsp_rdata, misaligned, bus_err,
        output mem_rden, mem_wren, mem_addr, mem_wdata, mem_byteen
    );

    // core plus DRAM model side
    modport master (
        output req_rd, req_wr, req_addr, req_wdata, req_size, req_unsigned,
        output mem_rdata, mem_ready,
        input  stall, rsp_valid, rsp_rdata, misaligned, bus_err,
        input  mem_rden, mem_wren, mem_addr, mem_wdata, mem_byteen
    );
endinterface

// File: rtl/riscv_dmem_ctrl.sv
// rtl/riscv_dmem_ctrl.sv - MEM-stage load/store controller with lane steering and ready watchdog
module riscv_dmem_ctrl #(
    parameter int ADDR_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    riscv_dmem_ctrl_if.slave      bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;
    localparam logic [7:0] WD_LAST  = 8'(TIMEOUT - 1);

    logic [1:0]  state;
    logic        op_wr;
    logic [1:0]  size_q;
    logic [2:0]  off_q;
    logic        uns_q;
    logic [7:0]  wd;

    logic        req;
    logic        mis_raw;
    logic        accept;
    logic [2:0]  off;
    logic [7:0]  byteen_c;
    logic [63:0] shifted;
    logic [63:0] load_ext;

    assign req = bus.req_rd | bus.req_wr;
    assign off = bus.req_addr[2:0];

    always_comb begin
        mis_raw = 1'b0;
        case (bus.req_size)
            2'b01:   mis_raw = off[0];
            2'b10:   mis_raw = |off[1:0];
            2'b11:   mis_raw = |off;
            default: mis_raw = 1'b0;
        endcase
    end

    assign accept         = (state == S_IDLE) && req && !mis_raw;
    assign bus.misaligned = rst_n && (state == S_IDLE) && req && mis_raw;
    assign bus.stall      = rst_n && (accept || (state == S_ACCESS));

    always_comb begin
        byteen_c = 8'h00;
        if (bus.req_wr) begin
            case (bus.req_size)
                2'b00:   byteen_c = 8'h01 << off;
                2'b01:   byteen_c = 8'h03 << off;
                2'b10:   byteen_c = 8'h0F << off;
                default: byteen_c = 8'hFF;
            endcase
        end
    end

    // Load lane extraction uses the offset/size latched at accept, not the live request.
    assign shifted = bus.mem_rdata >> {off_q, 3'b000};

    always_comb begin
        load_ext = shifted;
        case (size_q)
            2'b00:   load_ext = {{56{~uns_q & shifted[7]}},  shifted[7:0]};
            2'b01:   load_ext = {{48{~uns_q & shifted[15]}}, shifted[15:0]};
            2'b10:   load_ext = {{32{~uns_q & shifted[31]}}, shifted[31:0]};
            default: load_ext = shifted;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            op_wr          <= 1'b0;
            size_q         <= 2'b00;
            off_q          <= 3'b000;
            uns_q          <= 1'b0;
            wd             <= 8'd0;
            bus.mem_rden   <= 1'b0;
            bus.mem_wren   <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= 64'd0;
            bus.mem_byteen <= 8'h00;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_rdata  <= 64'd0;
            bus.bus_err    <= 1'b0;
        end else begin
            bus.rsp_valid <= 1'b0;
            bus.bus_err   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        bus.mem_addr   <= {bus.req_addr[ADDR_W-1:3], 3'b000};
                        bus.mem_wdata  <= bus.req_wdata << {off, 3'b000};
                        bus.mem_byteen <= byteen_c;
                        bus.mem_wren   <= bus.req_wr;
                        bus.mem_rden   <= ~bus.req_wr;
                        op_wr          <= bus.req_wr;
                        size_q         <= bus.req_size;
                        off_q          <= off;
                        uns_q          <= bus.req_unsigned;
                        wd             <= 8'd0;
                        state          <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    wd <= wd + 8'd1;
                    if (bus.mem_ready) begin
                        bus.mem_rden  <= 1'b0;
                        bus.mem_wren  <= 1'b0;
                        bus.rsp_valid <= 1'b1;
                        if (!op_wr) begin
                            bus.rsp_rdata <= load_ext;
                        end
                        state <= S_DONE;
                    end else if (wd == WD_LAST) begin
                        bus.mem_rden <= 1'b0;
                        bus.mem_wren <= 1'b0;
                        bus.bus_err  <= 1'b1;
                        state        <= S_DONE;
                    end
                end
                // DONE forces one enable-low cycle so the DRAM counter can rearm.
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_riscv_dmem_ctrl.sv
// tb/tb_riscv_dmem_ctrl.sv - directed plus randomized load/store checks against a byte-level model
module tb_riscv_dmem_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    bit   ready_kill = 1'b0;
    int   dram_cnt;
    logic [63:0] exp_rdata = 64'd0;

    always #5 clk = ~clk;

    riscv_dmem_ctrl_if #(.ADDR_W(64)) bus ();

    riscv_dmem_ctrl #(.ADDR_W(64), .TIMEOUT(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // DRAM latency model: ready registered after three counted enable cycles
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dram_cnt      <= 0;
            bus.mem_ready <= 1'b0;
        end else if ((bus.mem_rden || bus.mem_wren) && !ready_kill) begin
            bus.mem_ready <= (dram_cnt == 3);
            dram_cnt      <= dram_cnt + 1;
        end else begin
            dram_cnt      <= 0;
            bus.mem_ready <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] ref_load(input logic [63:0] rd, input int off, input int size, input bit uns);
        int nb = 1 << size;
        logic [63:0] r = 64'd0;
        for (int i = 0; i < nb; i++) r[8*i +: 8] = rd[8*(off+i) +: 8];
        if (!uns && r[8*nb-1]) for (int i = nb; i < 8; i++) r[8*i +: 8] = 8'hFF;
        return r;
    endfunction

    function automatic logic [7:0] ref_be(input int off, input int size);
        logic [7:0] b = 8'h00;
        for (int i = 0; i < (1 << size); i++) b[off+i] = 1'b1;
        return b;
    endfunction

    task automatic drop_req();
        bus.req_rd = 1'b0;
        bus.req_wr = 1'b0;
    endtask

    // Call in cycle 0 (just after an edge); returns in cycle 7 with the request dropped.
    task automatic do_access(input bit wr, input logic [63:0] addr, input logic [63:0] wdata,
                             input logic [1:0] size, input bit uns, input logic [63:0] rdata);
        int off = int'(addr[2:0]);
        logic [7:0]  exp_be = wr ? ref_be(off, int'(size)) : 8'h00;
        logic [63:0] exp_w  = wdata << (8*off);
        bus.req_rd = !wr;  bus.req_wr = wr;  bus.req_addr = addr;
        bus.req_wdata = wdata;  bus.req_size = size;  bus.req_unsigned = uns;
        bus.mem_rdata = rdata;
        #1;
        check("c0_stall", 64'(bus.stall), 64'd1);
        check("c0_misaligned", 64'(bus.misaligned), 64'd0);
        for (int c = 1; c <= 5; c++) begin
            tick();
            check("acc_rden", 64'(bus.mem_rden), 64'(!wr));
            check("acc_wren", 64'(bus.mem_wren), 64'(wr));
            check("acc_stall", 64'(bus.stall), 64'd1);
            check("acc_rsp_valid", 64'(bus.rsp_valid), 64'd0);
            if (c == 1) begin
                check("mem_addr", bus.mem_addr, {addr[63:3], 3'b000});
                check("mem_byteen", 64'(bus.mem_byteen), 64'(exp_be));
                check("mem_wdata", bus.mem_wdata, exp_w);
            end
        end
        if (!wr) exp_rdata = ref_load(rdata, off, int'(size), uns);
        tick();
        check("done_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        check("done_stall", 64'(bus.stall), 64'd0);
        check("done_enables", 64'({bus.mem_rden, bus.mem_wren}), 64'd0);
        check("done_bus_err", 64'(bus.bus_err), 64'd0);
        check("rsp_rdata", bus.rsp_rdata, exp_rdata);
        tick();
        drop_req();
        #1;
        check("idle_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    endtask

    task automatic do_misaligned(input bit wr, input logic [63:0] addr, input logic [1:0] size);
        bus.req_rd = !wr;  bus.req_wr = wr;  bus.req_addr = addr;
        bus.req_size = size;  bus.req_unsigned = 1'b0;  bus.req_wdata = 64'd0;
        #1;
        check("mis_flag", 64'(bus.misaligned), 64'd1);
        check("mis_stall", 64'(bus.stall), 64'd0);
        for (int c = 0; c < 2; c++) begin
            tick();
            check("mis_no_enable", 64'({bus.mem_rden, bus.mem_wren}), 64'd0);
        end
        drop_req();
        tick();
        check("mis_cleared", 64'(bus.misaligned), 64'd0);
    endtask

    initial begin
        drop_req();
        bus.req_addr = '0;  bus.req_wdata = 64'd0;  bus.req_size = 2'b00;
        bus.req_unsigned = 1'b0;  bus.mem_rdata = 64'd0;
        bus.req_rd = 1'b1;
        #1;
        check("rst_stall", 64'(bus.stall), 64'd0);
        check("rst_outputs", 64'({bus.mem_rden, bus.mem_wren, bus.rsp_valid, bus.bus_err}), 64'd0);
        check("rst_rsp_rdata", bus.rsp_rdata, 64'd0);
        drop_req();
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        do_access(1'b0, 64'h1004, 64'd0, 2'b10, 1'b0, 64'h80000000_12345678);
        check("lw_value", bus.rsp_rdata, 64'hFFFFFFFF_80000000);
        do_access(1'b0, 64'h2007, 64'd0, 2'b00, 1'b1, 64'hAB000000_00000000);
        check("lbu_value", bus.rsp_rdata, 64'h00000000_000000AB);
        do_access(1'b0, 64'h2007, 64'd0, 2'b00, 1'b0, 64'hAB000000_00000000);
        check("lb_value", bus.rsp_rdata, 64'hFFFFFFFF_FFFFFFAB);
        do_access(1'b1, 64'h3002, 64'h0000_BEEF, 2'b01, 1'b0, 64'h5555_5555_5555_5555);
        check("sh_keeps_rdata", bus.rsp_rdata, 64'hFFFFFFFF_FFFFFFAB);
        do_misaligned(1'b0, 64'h4002, 2'b10);

        // watchdog abort with ready held low
        ready_kill = 1'b1;
        bus.req_rd = 1'b1;  bus.req_addr = 64'h5000;  bus.req_size = 2'b11;
        #1;
        for (int c = 1; c <= 16; c++) begin
            tick();
            check("wd_rden_high", 64'(bus.mem_rden), 64'd1);
        end
        tick();
        check("wd_rden_drop", 64'(bus.mem_rden), 64'd0);
        check("wd_bus_err", 64'(bus.bus_err), 64'd1);
        check("wd_no_rsp", 64'(bus.rsp_valid), 64'd0);
        check("wd_rdata_kept", bus.rsp_rdata, exp_rdata);
        drop_req();
        tick();
        check("wd_err_once", 64'(bus.bus_err), 64'd0);
        check("wd_idle_stall", 64'(bus.stall), 64'd0);
        ready_kill = 1'b0;
        tick();

        // reset in cycle 3 of a load
        bus.req_rd = 1'b1;  bus.req_addr = 64'h6008;  bus.req_size = 2'b11;
        bus.mem_rdata = 64'h0123_4567_89AB_CDEF;
        tick(); tick(); tick();
        check("pre_rst_rden", 64'(bus.mem_rden), 64'd1);
        rst_n = 1'b0;
        drop_req();
        exp_rdata = 64'd0;
        #1;
        check("rst_rden_drop", 64'(bus.mem_rden), 64'd0);
        check("rst_stall_low", 64'(bus.stall), 64'd0);
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            check("post_rst_no_rsp", 64'({bus.rsp_valid, bus.mem_rden}), 64'd0);
        end
        do_access(1'b0, 64'h6008, 64'd0, 2'b11, 1'b0, 64'h0123_4567_89AB_CDEF);

        for (int n = 0; n < 40; n++) begin
            bit          wr   = 1'($urandom_range(0, 1));
            logic [1:0]  size = 2'($urandom_range(0, 3));
            logic [63:0] addr = {$urandom, $urandom};
            logic [2:0]  mask = 3'((1 << size) - 1);
            if (size != 2'b00 && $urandom_range(0, 4) == 0) begin
                logic [2:0] low = 3'($urandom_range(1, int'(mask)));
                addr[2:0] = (addr[2:0] & ~mask) | low;
                do_misaligned(wr, addr, size);
            end else begin
                addr[2:0] = addr[2:0] & ~mask;
                do_access(wr, addr, {$urandom, $urandom}, size, 1'($urandom_range(0, 1)),
                          {$urandom, $urandom});
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/riscv_dmem_ctrl.md
# riscv_dmem_ctrl

Data-memory access controller between the pipeline MEM stage and the DRAM latency model. It accepts one load or store from the core, freezes the pipeline, and drives a DRAM read/write enable until the DRAM returns `mem_ready`. It then returns the aligned and extended load data, or retires the store. It also handles byte-lane steering, misalignment detection and a ready-timeout watchdog.

## Interface
- `ADDR_W`, 64: request address width.
- `TIMEOUT`, 255: maximum ACCESS cycles before abort; 8-bit range, minimum 8.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_rd` in 1: load request; held by the core while `stall`=1.
- `req_wr` in 1: store request; takes priority over `req_rd` if both are high.
- `req_addr` in ADDR_W: byte address.
- `req_wdata` in 64: store data, right-justified.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 dword.
- `req_unsigned` in 1: zero-extend the load (LBU/LHU/LWU).
- `stall` out 1: freezes the pipeline while an access is pending.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_rdata` out 64: extended load data; holds its value until the next load completes.
- `misaligned` out 1: address not aligned to `req_size`; no access is performed.
- `bus_err` out 1: one-cycle pulse on watchdog abort.
- `mem_rden` out 1: DRAM read enable.
- `mem_wren` out 1: DRAM write enable.
- `mem_addr` out ADDR_W: dword-aligned address, `{req_addr[ADDR_W-1:3],3'b0}`.
- `mem_wdata` out 64: store data shifted into its byte lanes.
- `mem_byteen` out 8: byte-lane write enables.
- `mem_rdata` in 64: DRAM read data; valid when `mem_ready`=1.
- `mem_ready` in 1: registered completion from the DRAM latency counter.

## Operation
- FSM states are IDLE, ACCESS and DONE. All outputs are registered except `stall` and `misaligned`.
- IDLE:
  - `misaligned` = request present AND the low address bits are not aligned:
    - half: `addr[0]`≠0
    - word: `addr[1:0]`≠0
    - dword: `addr[2:0]`≠0
    - byte: never misaligned.
  - Misaligned requests stay in IDLE with `stall`=0 so the pipeline can trap.
- Aligned request in IDLE:
  - `stall`=1 combinationally.
  - On the clock edge: register `mem_addr`, `mem_wdata` = `req_wdata << 8*addr[2:0]` and `mem_byteen`. Latch the op, size, offset and unsigned flag. Clear the watchdog. Move to ACCESS.
- Byte enables: byte 0x01<<off, half 0x03<<off, word 0x0F<<off, dword 0xFF. For reads `mem_byteen`=0x00.
- ACCESS:
  - `mem_rden` or `mem_wren` is held at 1 and `stall`=1. The watchdog increments every cycle.
  - On an edge with `mem_ready`=1: for loads, capture `mem_rdata >> 8*off`, truncate to size, sign- or zero-extend into `rsp_rdata`. Drop the enables and go to DONE.
  - On an edge with the watchdog = TIMEOUT-1 and `mem_ready`=0: drop the enables, pulse `bus_err`, go to DONE. `rsp_rdata` is unchanged.
- DONE:
  - `rsp_valid`=1 (not pulsed after a watchdog abort), `stall`=0, enables 0. The pipeline advances at this edge.
  - Unconditionally go to IDLE. No request is accepted in DONE, which guarantees at least one enable-low cycle between accesses so the DRAM counter returns to 0.
- `mem_ready` is ignored in IDLE and DONE.
- Stores never modify `rsp_rdata`.

## Timing
- Reset (async, `rst_n`=0): state IDLE. All of the following are 0: `mem_rden`, `mem_wren`, `mem_addr`, `mem_wdata`, `mem_byteen`, `rsp_valid`, `rsp_rdata`, `bus_err`, watchdog. `stall` and `misaligned` are forced to 0 while `rst_n`=0.
- Reset during ACCESS drops the enables immediately. No response is issued.
- Latency with the standard 3-count DRAM model, request first presented in cycle 0:
  - Enables are high in cycles 1–5.
  - `mem_ready`=1 in cycle 5.
  - `rsp_valid` is high in cycle 6.
  - `stall` is high in cycles 0–5.
  - The next request can be accepted from cycle 7 at the earliest.
- `rsp_rdata` becomes valid in the same cycle as `rsp_valid`.
- Back-to-back requests: one per 7 cycles.

## Test plan
- LW from 0x1004 with `mem_rdata`=0x80000000_12345678 -> `rsp_rdata`=0xFFFFFFFF_80000000 in cycle 6; `mem_addr`=0x1000; `stall` high cycles 0–5.
- LBU from 0x2007 with `mem_rdata`=0xAB00…00 -> `rsp_rdata`=0x00000000_000000AB. LB from the same address -> 0xFFFFFFFF_FFFFFFAB.
- SH to 0x3002 with data 0xBEEF -> `mem_byteen`=0x0C, `mem_wdata`=0x00000000_BEEF0000, `mem_wren` high cycles 1–5, `rsp_valid` in cycle 6, `rsp_rdata` unchanged.
- LW from 0x4002 -> `misaligned`=1 and `stall`=0 in the same cycle; no enable ever asserted.
- `mem_ready` tied to 0, TIMEOUT=16 -> enables drop after 16 ACCESS cycles, `bus_err` pulses once, `rsp_valid` stays 0, FSM returns to IDLE.
- `rst_n` asserted in cycle 3 of a load -> `mem_rden`=0 immediately, no `rsp_valid`; a new load after release completes normally.
